// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: state encoding and checksum target.
package boot_loader_pkg;

  typedef logic [2:0] ldr_state_t;

  localparam ldr_state_t LDR_IDLE  = 3'd0;
  localparam ldr_state_t LDR_LOAD  = 3'd1;
  localparam ldr_state_t LDR_CHECK = 3'd2;
  localparam ldr_state_t LDR_HOLD  = 3'd3;
  localparam ldr_state_t LDR_RUN   = 3'd4;
  localparam ldr_state_t LDR_ERROR = 3'd5;

  // Image bytes plus the trailing checksum byte must sum to this value.
  localparam int CHK_OK = 0;

endpackage

// File: rtl/ldr_byte_counter.sv
// Byte position and running additive checksum for the image being loaded.
module ldr_byte_counter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] count,
  output logic [DATA_W-1:0] sum,
  output logic              last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      sum   <= '0;
    end else if (clear) begin
      count <= '0;
      sum   <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
      sum   <= sum + data;
    end
  end

  // len == 0 encodes a full 2^ADDR_W image: len-1 wraps to all ones.
  assign last = (count == len - 1'b1);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Loads a program image from a host byte stream into memory, verifies its
// checksum, then holds and releases the CPU reset and hands it the memory port.
module boot_loader_ctrl
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cpu_reset,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_memdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              running,
  output logic              err,
  output ldr_state_t        dbg_state
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  ldr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] len_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] chk_total;
  logic              last;
  logic              start_acc;
  logic              accept;
  logic              chk_pass;
  logic              hold_done;

  // Stream handshake: a byte transfers on a rising edge where in_valid and
  // in_ready are both high; the host keeps in_data stable until then.
  assign accept    = in_valid & in_ready;
  assign start_acc = start & ((state == LDR_IDLE) | (state == LDR_RUN) |
                              (state == LDR_ERROR));
  assign chk_total = sum + in_data;
  assign chk_pass  = (chk_total == DATA_W'(CHK_OK));
  assign hold_done = (hold_cnt == HOLD_W'(RST_HOLD - 1));

  ldr_byte_counter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clear (start_acc),
    .accept(accept & (state == LDR_LOAD)),
    .len   (len_q),
    .data  (in_data),
    .count (count),
    .sum   (sum),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LDR_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q    <= '0;
      err      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (start_acc) begin
        len_q <= load_len;
        err   <= 1'b0;
      end else if ((state == LDR_CHECK) && accept && !chk_pass) begin
        err <= 1'b1;
      end
      if (state == LDR_HOLD) hold_cnt <= hold_cnt + 1'b1;
      else                   hold_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LDR_IDLE, LDR_RUN, LDR_ERROR: if (start_acc) state_nxt = LDR_LOAD;
      LDR_LOAD:  if (accept && last) state_nxt = LDR_CHECK;
      LDR_CHECK: if (accept) state_nxt = chk_pass ? LDR_HOLD : LDR_ERROR;
      LDR_HOLD:  if (hold_done) state_nxt = LDR_RUN;
      default:   state_nxt = LDR_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    busy      = 1'b0;
    running   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    case (state)
      LDR_LOAD: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        mem_we    = in_valid;
        mem_adr   = count;
        mem_wdata = in_data;
      end
      LDR_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      LDR_HOLD: busy = 1'b1;
      LDR_RUN: begin
        cpu_reset = 1'b0;
        running   = 1'b1;
        mem_re    = cpu_memread;
        mem_we    = cpu_memwrite;
        mem_adr   = cpu_adr;
        mem_wdata = cpu_writedata;
      end
      default: ;
    endcase
  end

  assign cpu_memdata = mem_rdata;
  assign dbg_state   = state;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: random image loads against a
// memory-image model, with a write scoreboard checked by a separate monitor.
module tb_boot_loader_ctrl;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int RST_HOLD = 4;
  localparam int W        = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] load_len = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              cpu_reset;
  logic              cpu_memread = 1'b0;
  logic              cpu_memwrite = 1'b0;
  logic [ADDR_W-1:0] cpu_adr = '0;
  logic [DATA_W-1:0] cpu_writedata = '0;
  logic [DATA_W-1:0] cpu_memdata;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              running;
  logic              err;
  logic [2:0]        dbg_state;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] ref_img[256];
  logic [DATA_W-1:0] img[256];
  logic [DATA_W-1:0] tb_mem[256];
  int                checks = 0;
  int                errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  boot_loader_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cpu_reset(cpu_reset), .cpu_memread(cpu_memread),
    .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr),
    .cpu_writedata(cpu_writedata), .cpu_memdata(cpu_memdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .running(running), .err(err), .dbg_state(dbg_state)
  );

  // Behavioural single-port memory behind the controller.
  always @(posedge clk) if (mem_we) tb_mem[mem_adr] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_adr];

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got adr=%0h data=%0h, expected no write",
                 mem_adr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_adr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL wr_data: got adr=%0h data=%0h, expected adr=%0h data=%0h",
                   mem_adr, mem_wdata, e[W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- helpers / drivers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] len);
    start = 1'b1;
    load_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [DATA_W-1:0] b);
    int  guard;
    bit  ok;
    guard = 0;
    ok = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!ok && guard < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      guard++;
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Streams img[0..n-1] with optional random idle gaps and, when send_ck is
  // set, a trailing checksum byte (correct or deliberately off by one).
  task automatic do_load(input int n, input bit good, input bit gaps,
                         input int poke, input bit send_ck);
    logic [DATA_W-1:0] sum;
    logic [ADDR_W-1:0] a;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (i == poke) pulse_start(8'd2);
      a = i[ADDR_W-1:0];
      exp_q.push_back({a, img[i]});
      ref_img[i] = img[i];
      sum = sum + img[i];
      send_byte(img[i]);
    end
    if (send_ck) send_byte(good ? (8'h00 - sum) : (8'h01 - sum));
  endtask

  task automatic expect_hold_then_run();
    for (int i = 0; i < RST_HOLD; i++) begin
      @(negedge clk);
      check("hold_cpu_reset", cpu_reset, 1);
      check("hold_running", running, 0);
    end
    @(negedge clk);
    check("run_running", running, 1);
    check("run_cpu_reset", cpu_reset, 0);
    @(posedge clk); #1;
  endtask

  task automatic readback(input logic [ADDR_W-1:0] a);
    cpu_adr = a;
    cpu_memread = 1'b1;
    @(negedge clk);
    check("rd_mem_re", mem_re, 1);
    check("rd_mem_adr", mem_adr, a);
    check("rd_cpu_memdata", cpu_memdata, ref_img[a]);
    @(posedge clk); #1;
    cpu_memread = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_running", running, 0);
    check("rst_err", err, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;

    // Good fixed load
    img[0] = 8'h20; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h05;
    pulse_start(8'd4);
    do_load(4, 1'b1, 1'b0, -1, 1'b1);
    expect_hold_then_run();
    for (int i = 0; i < 4; i++) readback(i[ADDR_W-1:0]);

    // RUN pass-through write
    cpu_adr = 8'h10; cpu_writedata = 8'h55; cpu_memwrite = 1'b1;
    exp_q.push_back({8'h10, 8'h55});
    ref_img[8'h10] = 8'h55;
    @(negedge clk);
    check("pt_mem_adr", mem_adr, 8'h10);
    check("pt_mem_we", mem_we, 1);
    check("pt_mem_wdata", mem_wdata, 8'h55);
    @(posedge clk); #1;

    // Reload from RUN; CPU write strobe stays high to test blocking
    cpu_adr = 8'h20; cpu_writedata = 8'hAA;
    exp_q.push_back({8'h20, 8'hAA});
    ref_img[8'h20] = 8'hAA;
    pulse_start(8'd8);
    @(negedge clk);
    check("reload_cpu_reset", cpu_reset, 1);
    check("reload_busy", busy, 1);
    check("reload_mem_we", mem_we, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) img[i] = 8'($urandom_range(0, 255));
    do_load(8, 1'b1, 1'b1, 3, 1'b1);
    cpu_memwrite = 1'b0;
    expect_hold_then_run();
    for (int i = 0; i < 8; i++) readback(i[ADDR_W-1:0]);

    // Bad checksum
    img[0] = 8'h20; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h05;
    pulse_start(8'd4);
    do_load(4, 1'b0, 1'b0, -1, 1'b1);
    cpu_memwrite = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bad_err", err, 1);
      check("bad_cpu_reset", cpu_reset, 1);
      check("bad_running", running, 0);
      check("bad_busy", busy, 0);
      @(posedge clk); #1;
    end
    cpu_memwrite = 1'b0;

    // Full-depth load from ERROR; start clears err
    pulse_start(8'd0);
    @(negedge clk);
    check("restart_err", err, 0);
    check("restart_busy", busy, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
    do_load(256, 1'b1, 1'b1, -1, 1'b1);
    expect_hold_then_run();
    readback(8'h00);
    readback(8'hFF);
    for (int i = 0; i < 6; i++) readback(8'($urandom_range(0, 255)));

    // Abort with reset after byte 100
    pulse_start(8'd0);
    for (int i = 0; i < 100; i++) img[i] = 8'($urandom_range(0, 255));
    do_load(100, 1'b1, 1'b0, -1, 1'b0);
    in_data = 8'h3C;
    in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_cpu_reset", cpu_reset, 1);
    check("abort_busy", busy, 0);
    check("abort_mem_we", mem_we, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_abort_busy", busy, 0);
    check("post_abort_err", err, 0);
    check("post_abort_cpu_reset", cpu_reset, 1);
    @(posedge clk); #1;

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
- Sequences CPU start-up by loading a program image into the shared 8-bit byte memory from a host byte stream, then releasing the CPU.
- Sits between the cpu and the single-port memory and owns the memory port.
  - While loading, the loader drives the port.
  - While running, the CPU's memread/memwrite/adr/writedata pass through.
- Verifies an 8-bit additive checksum and holds the CPU's synchronous active-high reset for a fixed number of clocks before release.

Parameters:
- ADDR_W, 8, memory address width; image length range is 1..2^ADDR_W.
- DATA_W, 8, memory and stream byte width.
- RST_HOLD, 4, clocks cpu_reset stays high in HOLD before RUN (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- load_len  in  ADDR_W  image byte count, sampled on accepted start; 0 means 2^ADDR_W.
- in_data  in  DATA_W  host stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- cpu_reset  out  1  to cpu reset, active-high.
- cpu_memread  in  1  from cpu.
- cpu_memwrite  in  1  from cpu.
- cpu_adr  in  ADDR_W  from cpu.
- cpu_writedata  in  DATA_W  from cpu.
- cpu_memdata  out  DATA_W  to cpu; always equals mem_rdata.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_adr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in LOAD, CHECK, HOLD.
- running  out  1  high in RUN.
- err  out  1  checksum mismatch; sticky until next accepted start.

Behaviour:
- State register: IDLE, LOAD, CHECK, HOLD, RUN, ERROR.
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - cpu_reset=1.
  - Count, sum and hold counter cleared.
  - err=0.
  - Memory strobes 0, mem_adr=0, mem_wdata=0.
  - in_ready=0, busy=0, running=0.
  - Reset asserted mid-load aborts immediately; memory contents are not restored.
- Byte acceptance: a byte is accepted when in_valid & in_ready are both high.
- start handling:
  - start is accepted only in IDLE, RUN or ERROR; it is ignored in LOAD, CHECK and HOLD.
  - On an accepted start: latch len; count=0; sum=0; err=0; cpu_reset=1 from the next cycle; go to LOAD.
  - In RUN, this re-asserts CPU reset and reloads.
- IDLE: cpu_reset=1, memory port idle.
- LOAD:
  - in_ready=1.
  - mem_we = in_valid; mem_adr = count; mem_wdata = in_data. These are combinational from the registered count, so zero latency.
  - On accept: count += 1; sum += in_data (mod 2^DATA_W).
  - When the accepted byte is number len-1, go to CHECK. With len=0, 2^ADDR_W bytes are accepted and count wraps to 0 without side effect.
- CHECK:
  - in_ready=1; mem_we=0. The checksum byte is not written to memory.
  - On accept, if (sum + in_data) mod 2^DATA_W == 0, go to HOLD; otherwise set err=1 and go to ERROR.
- HOLD:
  - cpu_reset=1; memory port idle.
  - Counts RST_HOLD cycles, then goes to RUN.
- RUN:
  - cpu_reset=0; running=1.
  - mem_re=cpu_memread, mem_we=cpu_memwrite, mem_adr=cpu_adr, mem_wdata=cpu_writedata (pure combinational pass-through).
- ERROR: cpu_reset=1; memory port idle; err=1.
- Outside LOAD and RUN: mem_we=0, mem_re=0, mem_adr=0, mem_wdata=0.
- CPU strobes are ignored in every state except RUN.
- in_valid with in_ready=0 is held by the host; no byte is lost or duplicated.
- Simultaneous start and last byte is impossible, because start is ignored in LOAD.

Decomposition:
- Shared package boot_loader_pkg:
  - State encoding constants (LDR_IDLE..LDR_ERROR, 3-bit).
  - CHK_OK constant (0).
- One sub-module, ldr_byte_counter:
  - Holds the ADDR_W-bit count and the DATA_W-bit running sum.
  - Inputs: clear and accept.
  - Outputs: count, sum, last (count == len-1).
- FSM and port muxing stay in boot_loader_ctrl.

Test Plan:
- Reset values: hold reset=0 for 3 cycles -> cpu_reset=1, busy=0, running=0, err=0, mem_we=0, in_ready=0; release, state stays IDLE.
- Good load:
  - Stimulus: start, load_len=4; stream 0x20,0x01,0x00,0x05, then checksum 0xDA.
  - Response: mem writes addr0..3 with those bytes; no write for 0xDA; cpu_reset high exactly 4 cycles after checksum accept, then 0; running=1.
- Bad checksum: same image with checksum 0xDB -> err=1, ERROR state, cpu_reset stays 1, no further memory writes; next start clears err.
- Backpressure and idle gaps: in_valid toggled 1-0-1 randomly over 8 bytes -> exactly 8 writes at addresses 0..7, sum correct, no duplicates.
- RUN pass-through and reload:
  - In RUN, cpu_adr=0x10, cpu_memwrite=1, cpu_writedata=0x55 -> mem_adr=0x10, mem_we=1, mem_wdata=0x55 in the same cycle.
  - start in RUN -> cpu_reset=1 next cycle; CPU strobes are blocked.
- Full-depth and abort:
  - load_len=0 -> 256 bytes written at 0x00..0xFF, then checksum.
  - Separately, reset=0 after byte 100 -> IDLE immediately, cpu_reset=1, in_ready=0.
